viterbi_traceback: RTL and testbench



---
 rtl/viterbi_traceback.sv | 106 ++++++++++
 tb/tb_viterbi_traceback.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks D survivor columns back from an end state after each new column
// and emits the oldest column's input bit. Define TRACEBACK_DBG_EN for a per-cycle trace print.
module viterbi_traceback #(
    parameter int M = 2,
    parameter int D = 6,
    localparam int TIME_W = (D > 1) ? $clog2(D) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] wr_ptr,
    input  logic [M-1:0]      s_end,
    input  logic              force_state0,
    output logic [TIME_W-1:0] tb_time,
    output logic [M-1:0]      tb_state,
    input  logic              tb_surv_bit,
    output logic              dec_bit_valid,
    output logic              dec_bit
);

    localparam int FILL_W = $clog2(D + 1);

    // Handshake: a column is announced by wr_ptr changing; dec_bit_valid is a one-cycle
    // pulse with no back-pressure, and dec_bit holds its value until the next pulse.
    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t              fsm;
    logic [TIME_W-1:0] wr_ptr_q;
    logic [TIME_W-1:0] step;
    logic [FILL_W-1:0] fill;
    logic              pending;
    logic              detect;
    logic              fill_ok;
    logic [M-1:0]      pred_state;
    logic [M-1:0]      start_state;

    assign detect      = (wr_ptr != wr_ptr_q);
    // fill counts columns before this one, so D-1 means the detected column completes D.
    assign fill_ok     = (fill >= FILL_W'(D - 1));
    assign start_state = force_state0 ? '0 : s_end;

    generate
        if (M == 1) begin : g_pred_m1
            assign pred_state = tb_surv_bit;
        end else begin : g_pred
            assign pred_state = {tb_state[M-2:0], tb_surv_bit};
        end
    endgenerate

    function automatic logic [TIME_W-1:0] prev_row(input logic [TIME_W-1:0] t);
        return (t == '0) ? TIME_W'(D - 1) : t - TIME_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= IDLE;
            wr_ptr_q      <= '0;
            step          <= '0;
            fill          <= '0;
            pending       <= 1'b0;
            tb_time       <= '0;
            tb_state      <= '0;
            dec_bit_valid <= 1'b0;
            dec_bit       <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr;
            dec_bit_valid <= 1'b0;
            if (detect && fill != FILL_W'(D))
                fill <= fill + FILL_W'(1);
            case (fsm)
                IDLE: begin
                    if (pending || (detect && fill_ok)) begin
                        tb_time  <= prev_row(wr_ptr);
                        tb_state <= start_state;
                        step     <= '0;
                        pending  <= 1'b0;
                        fsm      <= RUN;
                    end
                end
                RUN: begin
                    // Only one column can wait; later ones fold into the pending restart.
                    if (detect)
                        pending <= 1'b1;
                    if (step != TIME_W'(D - 1)) begin
                        tb_state <= pred_state;
                        tb_time  <= prev_row(tb_time);
                        step     <= step + TIME_W'(1);
                    end else begin
                        dec_bit       <= tb_state[M-1];
                        dec_bit_valid <= 1'b1;
                        fsm           <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef TRACEBACK_DBG_EN
    always @(posedge clk) begin
        $display("%0t tb fsm=%s step=%0d time=%0d state=%0d surv=%0b valid=%0b bit=%0b",
                 $time, fsm.name(), step, tb_time, tb_state, tb_surv_bit, dec_bit_valid, dec_bit);
    end
`else
`endif

endmodule

// File: tb/tb_viterbi_traceback.sv
// Bench for viterbi_traceback (M=2, D=6): drives a modelled survivor memory from a true encoder
// path and checks decoded bits against the input history.
module tb_viterbi_traceback;

    localparam int M  = 2;
    localparam int D  = 6;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] wr_ptr;
    logic [M-1:0]  s_end;
    logic          force_state0;
    logic [TW-1:0] tb_time;
    logic [M-1:0]  tb_state;
    logic          tb_surv_bit;
    logic          dec_bit_valid;
    logic          dec_bit;

    viterbi_traceback #(.M(M), .D(D)) dut (
        .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .s_end(s_end), .force_state0(force_state0),
        .tb_time(tb_time), .tb_state(tb_state), .tb_surv_bit(tb_surv_bit),
        .dec_bit_valid(dec_bit_valid), .dec_bit(dec_bit)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [0:5];

    always_comb begin
        tb_surv_bit = 1'b0;
        if (tb_time < TW'(D))
            tb_surv_bit = mem[tb_time][tb_state];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cur_state;
    int col_cnt;
    bit u_hist[$];
    bit got_q[$];
    int pulse_cnt;

    always @(posedge clk) begin
        #2;
        if (dec_bit_valid === 1'b1) begin
            got_q.push_back(dec_bit);
            pulse_cnt++;
        end
    end

    task automatic clear_model();
        cur_state = 0;
        col_cnt   = 0;
        pulse_cnt = 0;
        u_hist.delete();
        got_q.delete();
    endtask

    task automatic advance_ptr();
        wr_ptr = TW'((int'(wr_ptr) + 1) % D);
    endtask

    // One encoder step: the row keeps only the true path's survivor bit.
    task automatic write_column(input bit u);
        int row, nxt;
        row = int'(wr_ptr);
        nxt = (int'(u) << 1) | (cur_state >> 1);
        mem[row] = 4'b0;
        mem[row][nxt] = cur_state[0];
        u_hist.push_back(u);
        cur_state = nxt;
        col_cnt++;
        s_end = M'(nxt);
        advance_ptr();
    endtask

    task automatic write_raw(input logic [3:0] bits, input logic [M-1:0] se);
        mem[int'(wr_ptr)] = bits;
        s_end = se;
        advance_ptr();
    endtask

    function automatic bit ref_traceback(input int newest, input int start);
        int s, r;
        s = start;
        r = newest;
        for (int i = 0; i < D - 1; i++) begin
            s = ((s << 1) & 3) | int'(mem[r][s]);
            r = (r + D - 1) % D;
        end
        return s[1];
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        wr_ptr = '0;
        s_end = '0;
        force_state0 = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_ptr = '0;
        s_end = '0;
        force_state0 = 1'b0;
        for (int r = 0; r < D; r++) mem[r] = 4'b0;
        clear_model();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({tb_time, tb_state, dec_bit_valid, dec_bit} !== '0)
                $display("FAIL reset_outputs cycle %0d: got time=%0d state=%0d valid=%b bit=%b, want all 0",
                         c, tb_time, tb_state, dec_bit_valid, dec_bit);
            else n_pass++;
        end
        rst = 1'b0;
        wait_cycles(12);
        n_checks++;
        if (pulse_cnt !== 0) $display("FAIL reset_no_pulse: got %0d pulses, want 0", pulse_cnt);
        else n_pass++;
    endtask

    task automatic test_warmup();
        int exp_t;
        for (int t = 0; t < D - 1; t++) begin
            write_column(1'($urandom_range(0, 1)));
            wait_cycles(8);
        end
        n_checks++;
        if (pulse_cnt !== 0) $display("FAIL warmup_silent: got %0d pulses, want 0", pulse_cnt);
        else n_pass++;
        write_column(1'($urandom_range(0, 1)));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (dec_bit_valid !== (c == 7))
                $display("FAIL warmup_valid cycle %0d: got %b, want %b", c, dec_bit_valid, (c == 7));
            else n_pass++;
            if (c <= D) begin
                exp_t = (int'(wr_ptr) - c + 2 * D) % D;
                n_checks++;
                if (tb_time !== TW'(exp_t))
                    $display("FAIL warmup_time cycle %0d: got %0d, want %0d", c, tb_time, exp_t);
                else n_pass++;
            end
            if (c == 1) begin
                n_checks++;
                if (tb_state !== M'(cur_state))
                    $display("FAIL warmup_start_state: got %0d, want %0d", tb_state, cur_state);
                else n_pass++;
            end
            if (c == 7) begin
                n_checks++;
                if (dec_bit !== u_hist[0])
                    $display("FAIL warmup_bit: got %b, want %b", dec_bit, u_hist[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        int exp_t;
        write_column(1'($urandom_range(0, 1)));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= D) begin
                exp_t = (int'(wr_ptr) - c + 2 * D) % D;
                n_checks++;
                if (tb_time !== TW'(exp_t))
                    $display("FAIL wrap_time cycle %0d: got %0d, want %0d", c, tb_time, exp_t);
                else n_pass++;
            end
        end
        n_checks++;
        if (pulse_cnt !== 2 || got_q[1] !== u_hist[1])
            $display("FAIL wrap_bit: got %0d pulses last=%b, want 2 pulses last=%b",
                     pulse_cnt, got_q[got_q.size() - 1], u_hist[1]);
        else n_pass++;
    endtask

    task automatic test_stream();
        do_reset(3);
        for (int t = 0; t < 48; t++) begin
            write_column(t % 3 == 1);
            wait_cycles(8);
        end
        wait_cycles(4);
        n_checks++;
        if (pulse_cnt !== 43) $display("FAIL stream_count: got %0d, want 43", pulse_cnt);
        else n_pass++;
        for (int k = 0; k < got_q.size() && k < 43; k++) begin
            n_checks++;
            if (got_q[k] !== u_hist[k])
                $display("FAIL stream_bit %0d: got %b, want %b", k, got_q[k], u_hist[k]);
            else n_pass++;
        end
    endtask

    task automatic test_force_state0();
        logic [3:0]   tbl_bits  [3] = '{4'h0, 4'hF, 4'hF};
        logic [M-1:0] tbl_se    [3] = '{2'd3, 2'd3, 2'd3};
        bit           tbl_force [3] = '{1'b1, 1'b0, 1'b1};
        int newest, start, base;
        bit exp_bit;
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < D; r++) mem[r] = tbl_bits[i];
            force_state0 = tbl_force[i];
            newest = int'(wr_ptr);
            start = tbl_force[i] ? 0 : int'(tbl_se[i]);
            exp_bit = ref_traceback(newest, start);
            base = pulse_cnt;
            write_raw(tbl_bits[i], tbl_se[i]);
            @(negedge clk);
            n_checks++;
            if (tb_state !== M'(start))
                $display("FAIL force_start_state case %0d: got %0d, want %0d", i, tb_state, start);
            else n_pass++;
            wait_cycles(7);
            n_checks++;
            if (pulse_cnt !== base + 1 || got_q[got_q.size() - 1] !== exp_bit)
                $display("FAIL force_bit case %0d: got %0d pulses bit=%b, want 1 pulse bit=%b",
                         i, pulse_cnt - base, got_q[got_q.size() - 1], exp_bit);
            else n_pass++;
        end
        force_state0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int a, base;
        do_reset(3);
        for (int t = 0; t < D; t++) begin
            write_column(1'($urandom_range(0, 1)));
            wait_cycles(8);
        end
        base = got_q.size();
        a = col_cnt;
        write_column(1'($urandom_range(0, 1)));
        for (int c = 1; c <= 16; c++) begin
            if (c == 3 || c == 6) write_column(1'($urandom_range(0, 1)));
            @(negedge clk);
            if (c >= 7) begin
                n_checks++;
                if (dec_bit_valid !== (c == 7 || c == 14))
                    $display("FAIL b2b_valid cycle %0d: got %b, want %b", c, dec_bit_valid, (c == 7 || c == 14));
                else n_pass++;
            end
        end
        n_checks++;
        if (got_q.size() - base !== 2) $display("FAIL b2b_count: got %0d, want 2", got_q.size() - base);
        else n_pass++;
        if (got_q.size() - base == 2) begin
            n_checks++;
            if (got_q[base] !== u_hist[a - 5] || got_q[base + 1] !== u_hist[a + 2 - 5])
                $display("FAIL b2b_bits: got %b%b, want %b%b", got_q[base], got_q[base + 1],
                         u_hist[a - 5], u_hist[a + 2 - 5]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        int base;
        base = pulse_cnt;
        write_column(1'($urandom_range(0, 1)));
        wait_cycles(4);
        rst = 1'b1;
        wr_ptr = '0;
        s_end = '0;
        wait_cycles(4);
        n_checks++;
        if (pulse_cnt !== base) $display("FAIL midrun_abort: got %0d pulses, want 0", pulse_cnt - base);
        else n_pass++;
        rst = 1'b0;
        clear_model();
        for (int t = 0; t < D - 1; t++) begin
            write_column(1'($urandom_range(0, 1)));
            wait_cycles(8);
        end
        n_checks++;
        if (pulse_cnt !== 0) $display("FAIL midrun_refill: got %0d pulses, want 0", pulse_cnt);
        else n_pass++;
        write_column(1'($urandom_range(0, 1)));
        wait_cycles(8);
        n_checks++;
        if (pulse_cnt !== 1 || got_q[0] !== u_hist[0])
            $display("FAIL midrun_resume: got %0d pulses bit=%b, want 1 pulse bit=%b",
                     pulse_cnt, got_q[0], u_hist[0]);
        else n_pass++;
    endtask

    task automatic test_random_stream();
        for (int t = 0; t < 24; t++) begin
            write_column(1'($urandom_range(0, 1)));
            wait_cycles($urandom_range(8, 12));
        end
        n_checks++;
        if (got_q.size() !== col_cnt - (D - 1))
            $display("FAIL random_count: got %0d, want %0d", got_q.size(), col_cnt - (D - 1));
        else n_pass++;
        for (int k = 0; k < got_q.size() && k < col_cnt - (D - 1); k++) begin
            n_checks++;
            if (got_q[k] !== u_hist[k])
                $display("FAIL random_bit %0d: got %b, want %b", k, got_q[k], u_hist[k]);
            else n_pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_warmup();
        test_wrap();
        test_stream();
        test_force_state0();
        test_back_to_back();
        test_reset_mid_run();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
